bcd_countdown_timer: RTL and testbench

//  Egg-timer core. Turns four push-buttons into an HH:MM:SS.cc countdown held as 8 BCD digits.
//  v0..v7 feed the 8-digit multiplexed seven-segment display driver directly.

---
 rtl/bcd_countdown_timer_pkg.sv | 39 +++
 rtl/bcd_countdown_timer_if.sv | 30 +++
 rtl/bcd_countdown_timer_button_conditioner.sv | 49 ++++
 rtl/bcd_countdown_timer.sv | 155 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared FSM codes, field codes and BCD helpers for the egg timer
// Purpose: one home for the state encoding, edit-field codes, BCD limits and small BCD helpers.
// Ports: none (package).
package bcd_countdown_timer_pkg;

  typedef logic [3:0] bcdDigit_t;

  // FSM encoding kept as plain constants so older blocks can match on the raw bits.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] FLD_SEC = 2'd0;
  localparam logic [1:0] FLD_MIN = 2'd1;
  localparam logic [1:0] FLD_HR  = 2'd2;

  localparam bcdDigit_t  BCD_MAX_DIGIT   = 4'd9;
  localparam bcdDigit_t  BCD_MAX_TENS_60 = 4'd5;
  localparam logic [7:0] BCD_LIM_60      = 8'h59;
  localparam logic [7:0] BCD_LIM_99      = 8'h99;

  // Two-digit BCD increment that wraps to 00 after lim; never carries outward.
  function automatic logic [7:0] bcdIncWrap(input logic [7:0] val, input logic [7:0] lim);
    if (val == lim)
      return 8'h00;
    if (val[3:0] == BCD_MAX_DIGIT)
      return {val[7:4] + 4'd1, 4'd0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

  // Value a digit takes when it borrows: tens of sec/min (indices 3 and 5) reload 5, all others 9.
  function automatic bcdDigit_t digitLimit(input int idx);
    if (idx == 3 || idx == 5)
      return BCD_MAX_TENS_60;
    return BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - button/display bundle between board, timer core and display driver
// Purpose: groups the raw buttons and the timer outputs into one port.
// Signals:
//   btn_start, btn_clear, btn_sel, btn_up  raw push-buttons (master drives)
//   v0..v7      BCD digits, v0/v1 cc, v2/v3 sec, v4/v5 min, v6/v7 hr (slave drives)
//   sel_field   edit field 0 SEC, 1 MIN, 2 HR
//   running     high while counting down
//   alarm       high when the countdown has expired
interface bcd_countdown_timer_if;
  import bcd_countdown_timer_pkg::*;

  logic      btn_start;
  logic      btn_clear;
  logic      btn_sel;
  logic      btn_up;
  bcdDigit_t v0, v1, v2, v3, v4, v5, v6, v7;
  logic [1:0] sel_field;
  logic      running;
  logic      alarm;

  modport master (
    output btn_start, btn_clear, btn_sel, btn_up,
    input  v0, v1, v2, v3, v4, v5, v6, v7, sel_field, running, alarm
  );

  modport slave (
    input  btn_start, btn_clear, btn_sel, btn_up,
    output v0, v1, v2, v3, v4, v5, v6, v7, sel_field, running, alarm
  );
endinterface

// File: rtl/bcd_countdown_timer_button_conditioner.sv
// rtl/bcd_countdown_timer_button_conditioner.sv - 2-FF sync, debounce and rising-edge pulse for one button
// Purpose: turns a bouncy raw button into a single 1-clk pulse per accepted press.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   btnRaw  raw asynchronous button level
//   pulse   1-clk pulse when a new high level has been stable for DEBOUNCE_CYCLES clocks
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnRaw,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync1;
  logic             sync2;
  logic             stableLvl;
  logic [CNT_W-1:0] cnt;

  // cnt measures how long the synchronised level has disagreed with the accepted level;
  // any return to agreement restarts it, so short glitches never get accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      stableLvl <= 1'b0;
      cnt       <= '0;
      pulse     <= 1'b0;
    end else begin
      sync1 <= btnRaw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != stableLvl) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stableLvl <= sync2;
          cnt       <= '0;
          pulse     <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - egg-timer core: four buttons in, HH:MM:SS.cc BCD countdown out
// Purpose: edit/run/pause/alarm FSM with a BCD borrow-chain countdown on a 10 ms tick.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of bcd_countdown_timer_if: raw buttons in; v0..v7, sel_field, running, alarm out
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_DIV        = CLK_HZ / 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic clk,
  input logic rst_n,
  bcd_countdown_timer_if.slave bus
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic pStart, pClear, pSel, pUp;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStart (
    .clk(clk), .rst_n(rst_n), .btnRaw(bus.btn_start), .pulse(pStart));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uClear (
    .clk(clk), .rst_n(rst_n), .btnRaw(bus.btn_clear), .pulse(pClear));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSel (
    .clk(clk), .rst_n(rst_n), .btnRaw(bus.btn_sel), .pulse(pSel));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUp (
    .clk(clk), .rst_n(rst_n), .btnRaw(bus.btn_up), .pulse(pUp));

  logic [1:0]        state, stateNxt;
  logic [1:0]        selField, selFieldNxt;
  logic [TICK_W-1:0] tickCnt, tickCntNxt;
  bcdDigit_t         dig[8], digNxt[8], digDec[8];
  logic              running, alarm;
  logic              tick, allZero, decZero;
  logic [7:0]        fieldVal, fieldLim, fieldInc;

  assign tick = (state == ST_RUN) && (tickCnt == TICK_W'(TICK_DIV - 1));

  // Borrow ripples up from the cc units digit; a zero digit reloads its limit and passes the borrow on.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      digDec[i] = dig[i];
      if (borrow) begin
        if (dig[i] == 4'd0) begin
          digDec[i] = digitLimit(i);
        end else begin
          digDec[i] = dig[i] - 4'd1;
          borrow    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    allZero = 1'b1;
    decZero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (dig[i] != 4'd0)    allZero = 1'b0;
      if (digDec[i] != 4'd0) decZero = 1'b0;
    end
  end

  always_comb begin
    case (selField)
      FLD_MIN: begin fieldVal = {dig[5], dig[4]}; fieldLim = BCD_LIM_60; end
      FLD_HR:  begin fieldVal = {dig[7], dig[6]}; fieldLim = BCD_LIM_99; end
      default: begin fieldVal = {dig[3], dig[2]}; fieldLim = BCD_LIM_60; end
    endcase
    fieldInc = bcdIncWrap(fieldVal, fieldLim);
  end

  // The if/else order is the button priority: clear, then start, then sel, then up.
  always_comb begin
    stateNxt    = state;
    digNxt      = dig;
    selFieldNxt = selField;
    tickCntNxt  = tickCnt;
    if (state == ST_RUN)
      tickCntNxt = tick ? '0 : tickCnt + TICK_W'(1);

    if (pClear) begin
      stateNxt    = ST_IDLE;
      selFieldNxt = FLD_SEC;
      tickCntNxt  = '0;
      for (int i = 0; i < 8; i++) digNxt[i] = 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (pStart) begin
            if (!allZero) begin
              stateNxt = ST_RUN;
              // Resuming from PAUSE keeps the partial tick so cc timing is not stretched.
              if (state == ST_IDLE) tickCntNxt = '0;
            end else begin
              stateNxt = ST_IDLE;
            end
          end else if (pSel) begin
            selFieldNxt = (selField == FLD_HR) ? FLD_SEC : selField + 2'd1;
          end else if (pUp) begin
            case (selField)
              FLD_MIN: {digNxt[5], digNxt[4]} = fieldInc;
              FLD_HR:  {digNxt[7], digNxt[6]} = fieldInc;
              default: {digNxt[3], digNxt[2]} = fieldInc;
            endcase
          end
        end
        ST_RUN: begin
          if (pStart) begin
            stateNxt = ST_PAUSE;
          end else if (tick) begin
            digNxt = digDec;
            if (decZero) stateNxt = ST_DONE;
          end
        end
        default: begin
          if (pStart) stateNxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      selField <= FLD_SEC;
      tickCnt  <= '0;
      running  <= 1'b0;
      alarm    <= 1'b0;
      for (int i = 0; i < 8; i++) dig[i] <= 4'd0;
    end else begin
      state    <= stateNxt;
      selField <= selFieldNxt;
      tickCnt  <= tickCntNxt;
      running  <= (stateNxt == ST_RUN);
      alarm    <= (stateNxt == ST_DONE);
      for (int i = 0; i < 8; i++) dig[i] <= digNxt[i];
    end
  end

  assign bus.v0        = dig[0];
  assign bus.v1        = dig[1];
  assign bus.v2        = dig[2];
  assign bus.v3        = dig[3];
  assign bus.v4        = dig[4];
  assign bus.v5        = dig[5];
  assign bus.v6        = dig[6];
  assign bus.v7        = dig[7];
  assign bus.sel_field = selField;
  assign bus.running   = running;
  assign bus.alarm     = alarm;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int HOLD     = 8;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_CLEAR = 4'b0010;
  localparam logic [3:0] B_SEL   = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b1000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_countdown_timer_if tif ();

  bcd_countdown_timer #(
    .CLK_HZ(400),
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] digits();
    return {tif.v7, tif.v6, tif.v5, tif.v4, tif.v3, tif.v2, tif.v1, tif.v0};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic driveBtns(input logic [3:0] mask);
    tif.btn_start = mask[0];
    tif.btn_clear = mask[1];
    tif.btn_sel   = mask[2];
    tif.btn_up    = mask[3];
  endtask

  task automatic pressBtn(input logic [3:0] mask);
    driveBtns(mask);
    repeat (HOLD) @(negedge clk);
    driveBtns(4'b0000);
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic pressN(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) pressBtn(mask);
  endtask

  // Holds start until running rises; returns at the negedge right after the RUN-entry edge.
  task automatic startRun(input string tag);
    bit seen;
    seen = 1'b0;
    tif.btn_start = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (tif.running === 1'b1) seen = 1'b1;
    end
    tif.btn_start = 1'b0;
    checkValue(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    driveBtns(4'b0000);
    repeat (3) @(negedge clk);
    checkValue("rst_digits", digits(), 32'h0000_0000);
    checkValue("rst_running", {31'd0, tif.running}, 32'd0);
    checkValue("rst_alarm", {31'd0, tif.alarm}, 32'd0);
    checkValue("rst_sel", {30'd0, tif.sel_field}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load 00:03:02 via MIN then SEC, count down and check tick arithmetic.
    pressBtn(B_SEL);
    checkValue("sel_min", {30'd0, tif.sel_field}, 32'd1);
    pressN(B_UP, 3);
    pressN(B_SEL, 2);
    pressN(B_UP, 62);
    checkValue("load_3m02", digits(), 32'h0003_0200);
    startRun("run_a");
    checkValue("run_entry", digits(), 32'h0003_0200);
    repeat (4) @(negedge clk);
    checkValue("tick1", digits(), 32'h0003_0199);
    repeat (400) @(negedge clk);
    checkValue("tick101", digits(), 32'h0003_0099);
    checkValue("run_flag", {31'd0, tif.running}, 32'd1);

    // Asynchronous reset mid-RUN.
    rst_n = 1'b0;
    #1;
    checkValue("async_digits", digits(), 32'h0000_0000);
    checkValue("async_running", {31'd0, tif.running}, 32'd0);
    checkValue("async_alarm", {31'd0, tif.alarm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start with all zero stays IDLE.
    pressBtn(B_START);
    checkValue("zero_start_run", {31'd0, tif.running}, 32'd0);
    checkValue("zero_start_dig", digits(), 32'h0000_0000);

    // From 00:00:01.00 pause at .02 (between tick 98 and 99), resume, expire.
    pressBtn(B_UP);
    startRun("run_b");
    repeat (388) @(negedge clk);
    pressBtn(B_START);
    checkValue("pause_at_02", digits(), 32'h0000_0002);
    checkValue("pause_running", {31'd0, tif.running}, 32'd0);
    pressBtn(B_START);
    checkValue("done_digits", digits(), 32'h0000_0000);
    checkValue("done_alarm", {31'd0, tif.alarm}, 32'd1);
    checkValue("done_running", {31'd0, tif.running}, 32'd0);
    pressBtn(B_START);
    checkValue("ack_alarm", {31'd0, tif.alarm}, 32'd0);

    // Field wrap with no carry between fields.
    pressBtn(B_CLEAR);
    pressN(B_UP, 59);
    pressBtn(B_SEL);
    pressN(B_UP, 59);
    pressBtn(B_SEL);
    pressN(B_UP, 99);
    checkValue("load_max", digits(), 32'h9959_5900);
    pressBtn(B_UP);
    checkValue("hr_wrap", digits(), 32'h0059_5900);
    pressBtn(B_SEL);
    checkValue("sel_wrap", {30'd0, tif.sel_field}, 32'd0);
    pressBtn(B_UP);
    checkValue("sec_wrap", digits(), 32'h0059_0000);
    pressBtn(B_SEL);
    pressBtn(B_UP);
    checkValue("min_wrap", digits(), 32'h0000_0000);

    // Pause freezes, edit SEC while paused, resume from the edited value.
    pressBtn(B_CLEAR);
    pressN(B_UP, 5);
    startRun("run_c");
    checkValue("run_c_entry", digits(), 32'h0000_0500);
    repeat (36) @(negedge clk);
    pressBtn(B_START);
    checkValue("pause_490", digits(), 32'h0000_0490);
    checkValue("pause_c_running", {31'd0, tif.running}, 32'd0);
    repeat (20 * TICK_DIV) @(negedge clk);
    checkValue("frozen_490", digits(), 32'h0000_0490);
    pressBtn(B_UP);
    checkValue("edit_590", digits(), 32'h0000_0590);
    startRun("run_d");
    checkValue("resume_590", digits(), 32'h0000_0590);

    // clear and start in the same cycle during RUN: clear wins.
    repeat (10) @(negedge clk);
    pressBtn(B_CLEAR | B_START);
    checkValue("clr_win_dig", digits(), 32'h0000_0000);
    checkValue("clr_win_run", {31'd0, tif.running}, 32'd0);
    checkValue("clr_win_alarm", {31'd0, tif.alarm}, 32'd0);

    // A 2-clock glitch on up is rejected; a full press is accepted.
    tif.btn_up = 1'b1;
    repeat (2) @(negedge clk);
    tif.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    checkValue("glitch", digits(), 32'h0000_0000);
    pressBtn(B_UP);
    checkValue("after_glitch", digits(), 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
